// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the decode -> execute boundary:
//     - RV64 base opcode constants
//     - immediate format enum (imm_type_e)
//     - execute control bundle (ctrl_t) carried in the ID/EX register
//     - opcode classification helpers used by decode, hazard logic and imm_gen
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Controls that travel with the instruction into execute.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic alu_src;
    logic illegal;
  } ctrl_t;

  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    imm_type_e t;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
      OPC_STORE:                      t = IMM_S;
      OPC_BRANCH:                     t = IMM_B;
      OPC_LUI, OPC_AUIPC:             t = IMM_U;
      OPC_JAL:                        t = IMM_J;
      default:                        t = IMM_NONE;
    endcase
    return t;
  endfunction

  // Unknown opcodes only raise illegal; every other control stays low so the
  // instruction cannot write state.
  function automatic ctrl_t decode_ctrl(input logic [6:0] opc);
    ctrl_t c;
    c = '0;
    case (opc)
      OPC_OP: begin
        c.reg_write = 1'b1;
      end
      OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OPC_LOAD: begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src   = 1'b1;
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        c.branch = 1'b1;
      end
      default: begin
        c.illegal = 1'b1;
      end
    endcase
    return c;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    logic u;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: u = 1'b1;
      default: u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    logic u;
    case (opc)
      OPC_OP, OPC_STORE, OPC_BRANCH: u = 1'b1;
      default: u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
//   Combinational immediate generator. Selects the format from the opcode and
//   returns the sign-extended 64-bit immediate (0 for R-type / unknown).
//   Ports:
//     instr_i  in  32  instruction word
//     imm_o    out 64  sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [63:0] imm_o
);

  imm_type_e imm_type;

  assign imm_type = imm_type_of(instr_i[6:0]);

  always_comb begin
    imm_o = '0;
    case (imm_type)
      IMM_I: imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      // B and J encode offsets in halfwords: bit 0 is always zero.
      IMM_B: imm_o = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
      IMM_J: imm_o = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   Decode stage plus the ID/EX pipeline register of an in-order RV64 core.
//   Decodes the IF/ID instruction, reads operands (with writeback bypass),
//   generates the immediate, detects load-use hazards and registers everything
//   for execute.
//
//   Ports:
//     clk, reset                 clock, async active-high reset
//     if_valid/if_instr/if_pc    instruction held in IF/ID
//     readReg1/2, readData1/2    register-file read port
//     wb_regWrite/wb_rd/wb_data  writeback port (bypassed into decode)
//     flush                      kill the instruction in decode
//     stall                      load-use hazard: IF and IF/ID must hold
//     ex_*                       registered decode results for execute
//     bubble_count               saturating count of inserted bubbles
//
//   Flow control contract:
//     An instruction in IF/ID advances into ID/EX on the rising edge when
//     stall=0. stall is combinational from IF/ID and ID/EX state; upstream
//     must hold if_instr/if_pc/if_valid unchanged on any edge where stall=1.
//     flush has priority: it loads a bubble and forces stall low, so a killed
//     instruction never holds the front end. Every stall or flush edge loads a
//     bubble (ex_valid=0, all controls and data zero).
// -----------------------------------------------------------------------------
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [63:0] if_pc,

  output logic [4:0]  readReg1,
  output logic [4:0]  readReg2,
  input  logic [63:0] readData1,
  input  logic [63:0] readData2,

  input  logic        wb_regWrite,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,

  input  logic        flush,
  output logic        stall,

  output logic        ex_valid,
  output logic        ex_regWrite,
  output logic        ex_memRead,
  output logic        ex_memWrite,
  output logic        ex_branch,
  output logic        ex_aluSrc,
  output logic        ex_illegal,
  output logic [63:0] ex_pc,
  output logic [63:0] ex_rs1_data,
  output logic [63:0] ex_rs2_data,
  output logic [63:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,

  output logic [15:0] bubble_count
);

  // ---------------------------------------------------------------------------
  // Field extraction and decode
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  ctrl_t       dec_ctrl;
  logic        dec_uses_rs1, dec_uses_rs2;
  logic [63:0] dec_imm;
  logic [63:0] op1, op2;

  assign opcode = if_instr[6:0];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rd     = if_instr[11:7];

  // Register-file addresses are raw fields, presented even for invalid slots.
  assign readReg1 = rs1;
  assign readReg2 = rs2;

  assign dec_ctrl     = decode_ctrl(opcode);
  assign dec_uses_rs1 = uses_rs1(opcode);
  assign dec_uses_rs2 = uses_rs2(opcode);

  imm_gen u_imm_gen (
    .instr_i (if_instr),
    .imm_o   (dec_imm)
  );

  // x0 reads as zero even if writeback targets it; otherwise the value being
  // written this cycle wins over the (not yet updated) register file.
  function automatic logic [63:0] sel_operand(input logic [4:0]  rs,
                                              input logic [63:0] rf_data,
                                              input logic        wb_we,
                                              input logic [4:0]  wb_addr,
                                              input logic [63:0] wb_val);
    logic [63:0] v;
    if (rs == 5'd0)                      v = '0;
    else if (wb_we && (wb_addr == rs))   v = wb_val;
    else                                 v = rf_data;
    return v;
  endfunction

  assign op1 = sel_operand(rs1, readData1, wb_regWrite, wb_rd, wb_data);
  assign op2 = sel_operand(rs2, readData2, wb_regWrite, wb_rd, wb_data);

  // ---------------------------------------------------------------------------
  // ID/EX register state
  // ---------------------------------------------------------------------------
  logic        valid_q,    valid_d;
  ctrl_t       ctrl_q,     ctrl_d;
  logic [63:0] pc_q,       pc_d;
  logic [63:0] rs1_data_q, rs1_data_d;
  logic [63:0] rs2_data_q, rs2_data_d;
  logic [63:0] imm_q,      imm_d;
  logic [4:0]  rs1_q,      rs1_d;
  logic [4:0]  rs2_q,      rs2_d;
  logic [4:0]  rd_q,       rd_d;
  logic [2:0]  funct3_q,   funct3_d;
  logic        funct7b5_q, funct7b5_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // ---------------------------------------------------------------------------
  // Load-use hazard
  //   The load in execute cannot forward until after memory, so a consumer
  //   directly behind it must wait one cycle. A bubble always clears
  //   ctrl_q.mem_read, so two stalls in a row are impossible.
  // ---------------------------------------------------------------------------
  logic hazard;
  logic load_bubble;
  logic count_bubble;

  assign hazard = if_valid && valid_q && ctrl_q.mem_read && (rd_q != 5'd0) &&
                  (((rd_q == rs1) && dec_uses_rs1) ||
                   ((rd_q == rs2) && dec_uses_rs2));

  assign stall = hazard && !flush;

  assign load_bubble  = flush || stall;
  // A flush of an empty slot replaces nothing, so it is not counted.
  assign count_bubble = stall || (flush && if_valid);

  // ---------------------------------------------------------------------------
  // Next-state: bubble by default, capture when neither flush nor stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d    = 1'b0;
    ctrl_d     = '0;
    pc_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    funct3_d   = '0;
    funct7b5_d = 1'b0;

    if (!load_bubble) begin
      valid_d    = if_valid;
      // An empty slot still carries its fields but must not act on them.
      ctrl_d     = if_valid ? dec_ctrl : '0;
      pc_d       = if_pc;
      rs1_data_d = op1;
      rs2_data_d = op2;
      imm_d      = dec_imm;
      rs1_d      = rs1;
      rs2_d      = rs2;
      rd_d       = rd;
      funct3_d   = if_instr[14:12];
      funct7b5_d = if_instr[30];
    end

    bubble_cnt_d = bubble_cnt_q;
    if (count_bubble && (bubble_cnt_q != BUBBLE_CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct3_q     <= '0;
      funct7b5_q   <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      funct7b5_q   <= funct7b5_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ex_valid     = valid_q;
  assign ex_regWrite  = ctrl_q.reg_write;
  assign ex_memRead   = ctrl_q.mem_read;
  assign ex_memWrite  = ctrl_q.mem_write;
  assign ex_branch    = ctrl_q.branch;
  assign ex_aluSrc    = ctrl_q.alu_src;
  assign ex_illegal   = ctrl_q.illegal;
  assign ex_pc        = pc_q;
  assign ex_rs1_data  = rs1_data_q;
  assign ex_rs2_data  = rs2_data_q;
  assign ex_imm       = imm_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_funct3    = funct3_q;
  assign ex_funct7b5  = funct7b5_q;
  assign bubble_count = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high.
REQ-002 if_valid  in  1  IF/ID holds a valid instruction.
REQ-003 if_instr  in  32  instruction word; if_pc  in  64  its PC.
REQ-004 readReg1, readReg2  out  5  register-file read addresses.
REQ-005 readData1, readData2  in  64  register-file read data.
REQ-006 wb_regWrite  in  1, wb_rd  in  5, wb_data  in  64  writeback port, same values the register file receives.
REQ-007 flush  in  1  kill the instruction in decode (taken branch/jump).
REQ-008 stall  out  1  load-use hazard; IF and IF/ID SHALL hold.
REQ-009 ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_branch, ex_aluSrc, ex_illegal  out  1  registered controls.
REQ-010 ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  64; ex_rs1, ex_rs2, ex_rd  out  5; ex_funct3  out  3; ex_funct7b5  out  1.
REQ-011 bubble_count  out  16  count of inserted bubbles.

Function
REQ-012 readReg1 = if_instr[19:15], readReg2 = if_instr[24:20], combinational, independent of if_valid.
REQ-013 Operand select per source: rs==0 -> 0; else wb_regWrite && wb_rd==rs -> wb_data (bypass); else readData.
REQ-014 Immediate sign-extended to 64 bits: I for opcodes 0000011/0010011/1100111; S for 0100011; B for 1100011 (bit0=0); U for 0110111/0010111 (low 12 bits zero); J for 1101111 (bit0=0); R type -> 0.
REQ-015 Decode: regWrite for R(0110011), OP-IMM, load, LUI, AUIPC, JAL, JALR; memRead for load only; memWrite for store only; branch for B; aluSrc for all non-R, non-B types.
REQ-016 Unlisted opcode -> ex_illegal=1, ex_valid=1, regWrite/memRead/memWrite/branch=0.
REQ-017 Latency: decoded fields appear on ex_* one cycle after the capturing edge.
REQ-018 Load-use hazard = if_valid && ex_valid && ex_memRead && ex_rd!=0 && ((ex_rd==rs1 && type uses rs1) || (ex_rd==rs2 && type in R/S/B)); stall SHALL equal hazard && !flush, combinationally.
REQ-019 Edge priority: flush > stall > capture; flush or stall loads a bubble (ex_valid=0, all controls 0, data fields 0); otherwise capture, ex_valid=if_valid.
REQ-020 A second consecutive stall cannot occur since the bubble clears ex_memRead.
REQ-021 bubble_count increments on each edge loading a bubble caused by stall or by flush with if_valid=1; saturates at 0xFFFF.
REQ-022 if_valid=0 captures ex_valid=0 with all controls 0.

Reset
REQ-023 On reset assertion, immediately: all ex_* outputs 0, bubble_count 0; stall therefore 0.
REQ-024 Reset mid-stall discards the held instruction; first post-reset edge captures normally.

Structure
REQ-025 Opcode constants, immediate-type enum and control-bundle typedef SHALL live in shared package riscv_pkg.
REQ-026 Immediate generation SHALL be sub-module imm_gen (combinational, instr in, 64-bit imm out).

Verification
REQ-027 addi x5,x0,-1 (0xFFF00293) -> next cycle ex_imm=0xFFFF_FFFF_FFFF_FFFF, ex_rd=5, regWrite=1, aluSrc=1.
REQ-028 ld x6,0(x1) then add x7,x6,x2 -> stall=1 one cycle, bubble_count=1, add captured next cycle.
REQ-029 wb_regWrite=1, wb_rd=3, wb_data=0xDEAD while decoding add x4,x3,x3 with readData=0 -> ex_rs1_data=ex_rs2_data=0xDEAD.
REQ-030 flush=1 with hazard present -> stall=0, ex_valid=0 next cycle.
REQ-031 Opcode 0x7F -> ex_illegal=1, ex_regWrite=0; x0 source with wb_rd=0 write -> operand 0.
REQ-032 Reset asserted between clock edges during stall -> outputs 0 without an edge; 65540 forced bubbles -> bubble_count=0xFFFF.
